// File: rtl/sample_decompressor.sv
// ============================================================================
// Module  : sample_decompressor
// Brief   : Run-length decoder for 16-bit sample streams with valid/ready I/O.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sample_decompressor (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        idle
);

    typedef enum logic [1:0] {
        ST_FIRST = 2'd0,
        ST_LIT   = 2'd1,
        ST_CNT   = 2'd2,
        ST_EXP   = 2'd3
    } state_t;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    state_t      state, state_nxt;
    logic [15:0] last, last_nxt;
    logic [15:0] rem, rem_nxt;
    logic        cont, cont_nxt;
    logic [15:0] out_data_nxt;
    logic        out_valid_nxt;
    logic        out_free;
    logic        accept;

    assign out_free = !out_valid || out_ready;
    assign in_ready = (state != ST_EXP) && out_free && !clear;
    assign accept   = in_valid && in_ready;
    assign idle     = ((state == ST_FIRST) || (state == ST_LIT)) && !out_valid;

    always_comb begin
        state_nxt     = state;
        last_nxt      = last;
        rem_nxt       = rem;
        cont_nxt      = cont;
        out_data_nxt  = out_data;
        out_valid_nxt = out_valid;

        // A consumed word drops valid unless something below reloads it.
        if (out_valid && out_ready) begin
            out_valid_nxt = 1'b0;
        end

        if (clear) begin
            state_nxt     = ST_FIRST;
            out_valid_nxt = 1'b0;
            rem_nxt       = 16'd0;
            cont_nxt      = 1'b0;
        end else begin
            case (state)
                ST_FIRST: begin
                    if (accept) begin
                        out_data_nxt  = in_data;
                        out_valid_nxt = 1'b1;
                        last_nxt      = in_data;
                        state_nxt     = ST_LIT;
                    end
                end
                ST_LIT: begin
                    if (accept) begin
                        out_data_nxt  = in_data;
                        out_valid_nxt = 1'b1;
                        last_nxt      = in_data;
                        if (in_data == last) begin
                            state_nxt = ST_CNT;
                        end
                    end
                end
                ST_CNT: begin
                    if (accept) begin
                        if (in_data == 16'd0) begin
                            state_nxt = ST_LIT;
                        end else begin
                            rem_nxt   = in_data;
                            cont_nxt  = (in_data == CNT_MAX);
                            state_nxt = ST_EXP;
                        end
                    end
                end
                ST_EXP: begin
                    if (out_free) begin
                        out_data_nxt  = last;
                        out_valid_nxt = 1'b1;
                        rem_nxt       = rem - 16'd1;
                        // A saturated count means the encoder sends another count word.
                        if (rem == 16'd1) begin
                            state_nxt = cont ? ST_CNT : ST_LIT;
                        end
                    end
                end
                default: state_nxt = ST_FIRST;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_FIRST;
            last      <= 16'd0;
            rem       <= 16'd0;
            cont      <= 1'b0;
            out_data  <= 16'd0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            last      <= last_nxt;
            rem       <= rem_nxt;
            cont      <= cont_nxt;
            out_data  <= out_data_nxt;
            out_valid <= out_valid_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sample_decompressor.sv
// ============================================================================
// Module  : tb_sample_decompressor
// Brief   : Scoreboard bench: a stream-level RLE model fills the expected queue.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sample_decompressor;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        idle;

    sample_decompressor dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .idle      (idle)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_q[$];
    int          m_state = 0;
    logic [15:0] m_last = 16'd0;
    int          seen = 0;
    bit          rand_rdy = 1'b0;
    bit          prev_stall = 1'b0;
    logic [15:0] prev_data = 16'd0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Stream-level decoder: no timing, just what words must come out in order.
    task automatic model(input logic [15:0] w);
        case (m_state)
            0: begin
                exp_q.push_back(w);
                m_last  = w;
                m_state = 1;
            end
            1: begin
                exp_q.push_back(w);
                if (w == m_last) m_state = 2;
                m_last = w;
            end
            default: begin
                if (w == 16'd0) begin
                    m_state = 1;
                end else begin
                    for (int i = 0; i < int'(w); i++) exp_q.push_back(m_last);
                    m_state = (w == 16'hFFFF) ? 2 : 1;
                end
            end
        endcase
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_state = 0;
    endtask

    task automatic send(input logic [15:0] w);
        int budget;
        budget   = 0;
        in_data  = w;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            budget++;
            if (budget > 70000) break;
        end
        if (budget > 70000) begin
            chk("send_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            model(w);
        end
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 70000) begin
            @(posedge clk);
            budget++;
        end
        chk("drain", exp_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst || clear) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_data", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                seen++;
                if (exp_q.size() == 0) chk("unexpected_out", out_data, 32'hFFFFFFFF);
                else chk("out_data", out_data, exp_q.pop_front());
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        int base;
        rst       = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'd0;
        out_ready = 1'b1;
        #1;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_data", out_data, 16'd0);
        chk("rst_idle", idle, 1'b1);
        chk("rst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Plain literals appear one cycle after acceptance.
        send(16'h0001);
        chk("lat_0001", {out_valid, out_data}, {1'b1, 16'h0001});
        send(16'h0002);
        chk("lat_0002", {out_valid, out_data}, {1'b1, 16'h0002});
        send(16'h0003);
        chk("lat_0003", {out_valid, out_data}, {1'b1, 16'h0003});
        drain();

        send(16'h1234);
        send(16'h1234);
        send(16'h0003);
        chk("exp_blocks_in", in_ready, 1'b0);
        send(16'h5678);
        send(16'h1234);
        send(16'h1234);
        send(16'h0000);
        send(16'h5678);
        drain();

        // Same streams under random backpressure.
        rand_rdy = 1'b1;
        send(16'h1234);
        send(16'h1234);
        send(16'h0003);
        send(16'h5678);
        send(16'h1234);
        send(16'h1234);
        send(16'h0000);
        send(16'h5678);
        drain();
        rand_rdy = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain();

        // Saturated count continues into another count word.
        base = seen;
        send(16'h00AA);
        send(16'h00AA);
        send(16'hFFFF);
        send(16'h0000);
        chk("run_before_cnt", seen - base, 32'd65537);
        send(16'h00BB);
        drain();

        // Clear mid-expansion, then restart from the first-literal state.
        send(16'h0007);
        send(16'h0007);
        send(16'h0007);
        repeat (3) @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        chk("clr_valid", out_valid, 1'b0);
        chk("clr_idle", idle, 1'b1);
        model_reset();
        send(16'h0007);
        chk("clr_first", {out_valid, out_data}, {1'b1, 16'h0007});
        send(16'h0007);
        send(16'h0002);
        drain();
        chk("clr_end_idle", idle, 1'b1);

        // Asynchronous reset mid-run.
        send(16'h0042);
        send(16'h0042);
        send(16'h0010);
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_valid", out_valid, 1'b0);
        chk("arst_data", out_data, 16'd0);
        chk("arst_idle", idle, 1'b1);
        chk("arst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        send(16'h0099);
        chk("arst_first", {out_valid, out_data}, {1'b1, 16'h0099});
        send(16'h0099);
        send(16'h0003);
        send(16'h0042);
        drain();
        chk("end_idle", idle, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sample_decompressor.md
SAMPLE_DECOMPRESSOR -- requirements
Module: sample_decompressor

Interface
REQ-001 SHALL have ports: clk  input  1  clock, all logic on rising edge.
REQ-002 SHALL have ports: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: clear  input  1  synchronous decoder restart, active-high.
REQ-004 SHALL have ports: in_data  input  16  compressed stream word.
REQ-005 SHALL have ports: in_valid  input  1  in_data valid.
REQ-006 SHALL have ports: in_ready  output  1  decoder accepts word this cycle (combinational).
REQ-007 SHALL have ports: out_data  output  16  decoded sample word (registered).
REQ-008 SHALL have ports: out_valid  output  1  out_data valid (registered).
REQ-009 SHALL have ports: out_ready  input  1  downstream accepts out_data.
REQ-010 SHALL have ports: idle  output  1  high in ST_FIRST/ST_LIT with out_valid low.

Function
REQ-011 SHALL treat the input as run-length encoded: a literal is emitted as-is; two consecutive equal literals are followed by a count word N.
REQ-012 SHALL decode count N < 16'hFFFF as N further copies of the run value, after which the next word is a literal.
REQ-013 SHALL decode count 16'hFFFF as 65535 further copies, after which the next word is again a count.
REQ-014 SHALL transfer input when in_valid && in_ready, and output when out_valid && out_ready.
REQ-015 SHALL drive in_ready = (state != ST_EXP) && (!out_valid || out_ready) && !clear.
REQ-016 SHALL hold out_data stable while out_valid && !out_ready.
REQ-017 SHALL implement states ST_FIRST, ST_LIT, ST_CNT, ST_EXP; 16-bit registers last (run value) and rem (copies remaining); 1-bit cont.
REQ-018 SHALL, in ST_FIRST on accepted word W: out_data<=W, out_valid<=1, last<=W, go ST_LIT.
REQ-019 SHALL, in ST_LIT on accepted W: out_data<=W, out_valid<=1, last<=W; go ST_CNT if W==last, else stay.
REQ-020 SHALL, in ST_CNT on accepted N: if N==0 go ST_LIT with no output; else rem<=N, cont<=(N==16'hFFFF), go ST_EXP.
REQ-021 SHALL, in ST_EXP each cycle with (!out_valid || out_ready): out_data<=last, out_valid<=1, rem<=rem-1; when rem==1, go ST_CNT if cont else ST_LIT.
REQ-022 SHALL clear out_valid on output transfer when no new word is loaded that cycle.
REQ-023 SHALL produce an accepted literal on out_data the next cycle, and the first run copy two cycles after the count is accepted.
REQ-024 SHALL sustain one output word per cycle in ST_EXP while out_ready is held high.
REQ-025 SHALL, after a non-FFFF count, compare the next literal against the run value (ST_LIT rule), matching the encoder's recover behaviour.
REQ-026 SHALL, on clear, override any handshake that cycle: out_valid<=0, state<=ST_FIRST, rem<=0, cont<=0; no input accepted.

Reset
REQ-027 SHALL, on rst, immediately set state=ST_FIRST, out_valid=0, out_data=0, last=0, rem=0, cont=0; in_ready follows REQ-015 (high).
REQ-028 SHALL abandon any run in progress on rst or clear mid-expansion, without emitting further copies.

Verification
REQ-029 SHALL cover literals 0001,0002,0003 with out_ready=1 -> outputs 0001,0002,0003, each one cycle after acceptance.
REQ-030 SHALL cover 1234,1234,0003,5678 -> 1234 x5 then 5678; 1234,1234,0000,5678 -> 1234 x2 then 5678.
REQ-031 SHALL cover 00AA,00AA,FFFF,0000,00BB -> 00AA x65537 then 00BB, with in_ready low throughout expansion.
REQ-032 SHALL cover random out_ready toggling on REQ-030 stream -> identical sequence, no drop/duplicate, out_data stable while stalled.
REQ-033 SHALL cover clear pulse mid-expansion of 0007 count -> out_valid low next cycle; following 0007 emitted as first literal, then 0007 again enters ST_CNT.
REQ-034 SHALL cover rst asserted mid-run -> all outputs at reset values asynchronously; decoding restarts cleanly from ST_FIRST.
